// File: rtl/mem_arbiter.sv
// Arbiter that lets instruction fetch and data access share one single-port,
// variable-latency memory. A grant is held on the port until ack or timeout.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ireqF,
  input  logic [31:0] iaddrF,
  output logic [31:0] irdataF,
  output logic        ivalidF,
  input  logic        dreqM,
  input  logic        dweM,
  input  logic [31:0] daddrM,
  input  logic [31:0] dwdataM,
  output logic [31:0] drdataM,
  output logic        dvalidM,
  output logic        stallF,
  output logic        stallM,
  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] IBUSY = 2'd1;
  localparam logic [1:0] DBUSY = 2'd2;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  logic [1:0]  state;
  logic        last_i;
  logic [15:0] cnt;
  logic [29:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;

  logic ireq_eff;
  logic dreq_eff;
  logic grant_d;
  logic grant_i;
  logic done;
  logic timed_out;
  logic unused_addr_lsbs;

  // A forced completion returns zero instead of whatever sits on the bus.
  function automatic logic [31:0] sel_rdata(input logic ack, input logic [31:0] d);
    return ack ? d : 32'h0;
  endfunction

  assign unused_addr_lsbs = ^{iaddrF[1:0], daddrM[1:0]};

  assign ireq_eff  = ireqF & ~ivalidF;
  assign dreq_eff  = dreqM & ~dvalidM;
  // On a tie, the port that was not served last wins.
  assign grant_d   = dreq_eff & (~ireq_eff | last_i);
  assign grant_i   = ireq_eff & ~grant_d;
  assign done      = mem_ack | (cnt == TIMEOUT_W);
  assign timed_out = ~mem_ack & (cnt == TIMEOUT_W);

  assign stallF    = ireqF & ~ivalidF;
  assign stallM    = dreqM & ~dvalidM;
  assign mem_en    = (state != IDLE);
  assign mem_we    = we_q & (state == DBUSY);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last_i  <= 1'b1;
      cnt     <= 16'd0;
      addr_q  <= 30'd0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      irdataF <= 32'd0;
      drdataM <= 32'd0;
      ivalidF <= 1'b0;
      dvalidM <= 1'b0;
      err     <= 1'b0;
    end else begin
      ivalidF <= 1'b0;
      dvalidM <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state   <= DBUSY;
            last_i  <= 1'b0;
            cnt     <= 16'd0;
            addr_q  <= daddrM[31:2];
            we_q    <= dweM;
            wdata_q <= dwdataM;
          end else if (grant_i) begin
            state  <= IBUSY;
            last_i <= 1'b1;
            cnt    <= 16'd0;
            addr_q <= iaddrF[31:2];
            we_q   <= 1'b0;
          end
        end
        IBUSY: begin
          if (done) begin
            state   <= IDLE;
            irdataF <= sel_rdata(mem_ack, mem_rdata);
            ivalidF <= 1'b1;
            if (timed_out) err <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DBUSY: begin
          if (done) begin
            state   <= IDLE;
            dvalidM <= 1'b1;
            if (!we_q) drdataM <= sel_rdata(mem_ack, mem_rdata);
            if (timed_out) err <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
